// File: rtl/yarp_pkg.sv
// yarp_pkg: shared ALU op encoding, RV32I decode constants and issue FSM states
package yarp_pkg;

    localparam int NUM_REGS = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_OR   = 4'd5,
        OP_AND  = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLT  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/yarp_regfile.sv
// yarp_regfile: 32x32 register file, two operand read ports, one debug read port, one write port, x0 reads zero
module yarp_regfile
    import yarp_pkg::*;
#(
    parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic        we_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] dbg_data_o
);

    logic [31:0] r_mem [NUM_REGS];

    // Reset all registers; x0 is never written so it keeps reading as zero through the read masks
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= REG_RESET_VAL;
        end else if (we_i && wr_addr_i != 5'd0) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'h0 : r_mem[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'h0 : r_mem[rs2_addr_i];
    assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'h0 : r_mem[dbg_addr_i];

endmodule

// File: rtl/yarp_alu_issue.sv
// yarp_alu_issue: accepts RV32I OP/OP-IMM instructions, drives an external ALU and writes the result back
module yarp_alu_issue
    import yarp_pkg::*;
#(
    parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    output logic [31:0] alu_opr_a_o,
    output logic [31:0] alu_opr_b_o,
    output logic [3:0]  alu_op_sel_o,
    input  logic [31:0] alu_res_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        illegal_o,
    input  logic [4:0]  dbg_raddr_i,
    output logic [31:0] dbg_rdata_o
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_opr_a;
    logic [31:0] r_opr_b;
    logic [31:0] r_res;
    alu_op_e     r_op;
    logic [4:0]  r_rd;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_legal;
    logic        w_xfer;
    alu_op_e     w_op;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_is_r   = w_opcode == OPC_OP;
    assign w_is_i   = w_opcode == OPC_OP_IMM;
    assign w_imm    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_xfer   = instr_valid_i && r_state == IDLE;

    // R-type only allows the alternate funct7 on ADD/SUB and SRL/SRA; I-type shifts constrain the upper imm bits
    assign w_legal = w_is_r ? (w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == F3_ADD || w_f3 == F3_SR)))
                   : w_is_i ? (w_f3 == F3_SLL ? w_f7 == F7_BASE
                             : w_f3 == F3_SR  ? (w_f7 == F7_BASE || w_f7 == F7_ALT)
                             : 1'b1)
                   : 1'b0;

    // Map funct3 (plus instr[30] for SUB and SRA) to the ALU op select
    always_comb begin
        w_op = OP_ADD;
        case (w_f3)
            F3_ADD:  w_op = (w_is_r && instr_i[30]) ? OP_SUB : OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = instr_i[30] ? OP_SRA : OP_SRL;
            F3_OR:   w_op = OP_OR;
            F3_AND:  w_op = OP_AND;
            default: w_op = OP_ADD;
        endcase
    end

    yarp_regfile #(
        .REG_RESET_VAL (REG_RESET_VAL)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs1_addr_i (instr_i[19:15]),
        .rs2_addr_i (instr_i[24:20]),
        .dbg_addr_i (dbg_raddr_i),
        .we_i       (r_state == WB),
        .wr_addr_i  (r_rd),
        .wr_data_i  (r_res),
        .rs1_data_o (w_rs1_data),
        .rs2_data_o (w_rs2_data),
        .dbg_data_o (dbg_rdata_o)
    );

    // Next-state: accept legal instructions in IDLE, then a fixed EXEC -> WB -> IDLE walk
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_xfer && w_legal) ? EXEC : IDLE;
            EXEC:    w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Operand/op latch on accept, result capture in EXEC, one-cycle illegal flag on a rejected accept
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_opr_a   <= 32'h0;
            r_opr_b   <= 32'h0;
            r_op      <= OP_ADD;
            r_rd      <= 5'd0;
            r_res     <= 32'h0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_xfer && !w_legal;
            if (w_xfer && w_legal) begin
                r_opr_a <= w_rs1_data;
                r_opr_b <= w_is_r ? w_rs2_data : w_imm;
                r_op    <= w_op;
                r_rd    <= instr_i[11:7];
            end
            if (r_state == EXEC) r_res <= alu_res_i;
        end
    end

    assign instr_ready_o = r_state == IDLE;
    assign alu_opr_a_o   = r_opr_a;
    assign alu_opr_b_o   = r_opr_b;
    assign alu_op_sel_o  = r_op;
    assign wb_valid_o    = r_state == WB;
    assign wb_rd_o       = wb_valid_o ? r_rd : 5'd0;
    assign wb_data_o     = wb_valid_o ? r_res : 32'h0;
    assign illegal_o     = r_illegal;

endmodule

// File: tb/tb_yarp_alu_issue.sv
// tb_yarp_alu_issue: directed plus random instruction stream against a behavioural RV32I model
module tb_yarp_alu_issue;
    import yarp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        instr_ready;
    logic [31:0] alu_opr_a;
    logic [31:0] alu_opr_b;
    logic [3:0]  alu_op_sel;
    logic [31:0] alu_res;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_raddr = 5'd0;
    logic [31:0] dbg_rdata;

    int total = 0;
    int bad = 0;

    logic [31:0] rf [32];
    logic [31:0] exp_a = 32'h0;
    logic [31:0] exp_b = 32'h0;
    logic [3:0]  exp_op = 4'd0;

    yarp_alu_issue #(.REG_RESET_VAL(32'h0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_ready_o (instr_ready),
        .alu_opr_a_o   (alu_opr_a),
        .alu_opr_b_o   (alu_opr_b),
        .alu_op_sel_o  (alu_op_sel),
        .alu_res_i     (alu_res),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .illegal_o     (illegal),
        .dbg_raddr_i   (dbg_raddr),
        .dbg_rdata_o   (dbg_rdata)
    );

    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        alu_res = 32'h0;
        case (alu_op_sel)
            OP_ADD:  alu_res = alu_opr_a + alu_opr_b;
            OP_SUB:  alu_res = alu_opr_a - alu_opr_b;
            OP_SLL:  alu_res = alu_opr_a << alu_opr_b[4:0];
            OP_SRL:  alu_res = alu_opr_a >> alu_opr_b[4:0];
            OP_SRA:  alu_res = $unsigned($signed(alu_opr_a) >>> alu_opr_b[4:0]);
            OP_OR:   alu_res = alu_opr_a | alu_opr_b;
            OP_AND:  alu_res = alu_opr_a & alu_opr_b;
            OP_XOR:  alu_res = alu_opr_a ^ alu_opr_b;
            OP_SLTU: alu_res = {31'h0, alu_opr_a < alu_opr_b};
            OP_SLT:  alu_res = {31'h0, $signed(alu_opr_a) < $signed(alu_opr_b)};
            default: alu_res = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_rf(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : rf[r];
    endfunction

    // Architectural view of one instruction: legality, operands, op select and result
    function automatic void model(input logic [31:0] ins, output bit legal, output logic [3:0] op,
                                  output logic [31:0] a, output logic [31:0] b, output logic [31:0] res);
        bit is_r = ins[6:0] == 7'b0110011;
        bit is_i = ins[6:0] == 7'b0010011;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [4:0] sh;
        legal = 1'b1;
        if (!is_r && !is_i) legal = 1'b0;
        if (is_r && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
        if (is_r && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) legal = 1'b0;
        if (is_i && f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
        if (is_i && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
        a = rd_rf(ins[19:15]);
        b = is_r ? rd_rf(ins[24:20]) : {{20{ins[31]}}, ins[31:20]};
        sh = b[4:0];
        op = 4'd0;
        res = 32'h0;
        case (f3)
            3'd0: if (is_r && ins[30]) begin op = OP_SUB; res = a - b; end
                  else begin op = OP_ADD; res = a + b; end
            3'd1: begin op = OP_SLL; res = a << sh; end
            3'd2: begin op = OP_SLT; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            3'd3: begin op = OP_SLTU; res = (a < b) ? 32'd1 : 32'd0; end
            3'd4: begin op = OP_XOR; res = a ^ b; end
            3'd5: if (ins[30]) begin op = OP_SRA; res = $unsigned($signed(a) >>> sh); end
                  else begin op = OP_SRL; res = a >> sh; end
            3'd6: begin op = OP_OR; res = a | b; end
            default: begin op = OP_AND; res = a & b; end
        endcase
    endfunction

    task automatic run(input logic [31:0] ins);
        bit legal;
        logic [3:0] op;
        logic [31:0] a, b, res, rnd;
        logic [4:0] rd;
        rd = ins[11:7];
        model(ins, legal, op, a, b, res);
        chk("ready_idle", {31'h0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom;
        if (legal) begin
            exp_a = a;
            exp_b = b;
            exp_op = op;
            chk("ready_exec", {31'h0, instr_ready}, 32'd0);
            chk("wbv_exec", {31'h0, wb_valid}, 32'd0);
            chk("ill_exec", {31'h0, illegal}, 32'd0);
            chk("op_sel", {28'h0, alu_op_sel}, {28'h0, exp_op});
            chk("opr_a", alu_opr_a, exp_a);
            chk("opr_b", alu_opr_b, exp_b);
            dbg_raddr = rd;
            @(posedge clk); #1;
            chk("wbv_wb", {31'h0, wb_valid}, 32'd1);
            chk("ready_wb", {31'h0, instr_ready}, 32'd0);
            chk("ill_wb", {31'h0, illegal}, 32'd0);
            chk("wb_rd", {27'h0, wb_rd}, {27'h0, rd});
            chk("wb_data", wb_data, res);
            chk("dbg_old", dbg_rdata, rd_rf(rd));
            if (rd != 5'd0) rf[rd] = res;
            @(posedge clk); #1;
            chk("wbv_after", {31'h0, wb_valid}, 32'd0);
            chk("ready_after", {31'h0, instr_ready}, 32'd1);
            chk("dbg_new", dbg_rdata, rd_rf(rd));
        end else begin
            chk("ill_pulse", {31'h0, illegal}, 32'd1);
            chk("wbv_ill", {31'h0, wb_valid}, 32'd0);
            chk("ready_ill", {31'h0, instr_ready}, 32'd1);
            chk("opr_a_hold", alu_opr_a, exp_a);
            chk("opr_b_hold", alu_opr_b, exp_b);
            chk("op_hold", {28'h0, alu_op_sel}, {28'h0, exp_op});
            @(posedge clk); #1;
            chk("ill_drop", {31'h0, illegal}, 32'd0);
            chk("wbv_ill2", {31'h0, wb_valid}, 32'd0);
        end
        rnd = $urandom;
        dbg_raddr = rnd[4:0];
        #1;
        chk("dbg_probe", dbg_rdata, rd_rf(rnd[4:0]));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [31:0] s = $urandom;
        int k = $urandom_range(0, 9);
        if (k < 4) begin
            w[6:0] = OPC_OP;
            if (s[2:0] != 3'd0) w[31:25] = s[3] ? F7_ALT : F7_BASE;
        end else if (k < 8) begin
            w[6:0] = OPC_OP_IMM;
            if (w[13:12] == 2'b01 && s[2:0] != 3'd0) w[31:25] = s[3] ? F7_ALT : F7_BASE;
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, instr_ready}, 32'd1);
        chk("rst_wbv", {31'h0, wb_valid}, 32'd0);
        chk("rst_ill", {31'h0, illegal}, 32'd0);
        chk("rst_opr_a", alu_opr_a, 32'h0);
        chk("rst_opr_b", alu_opr_b, 32'h0);
        chk("rst_op", {28'h0, alu_op_sel}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run(32'h00500093);
        run(32'hFFD00113);
        run(32'h402081B3);
        dbg_raddr = 5'd3;
        #1;
        chk("sub_dbg_x3", dbg_rdata, 32'h8);
        run(32'h40115293);
        chk("srai_x5", rf[5], 32'hFFFFFFFE);
        run(32'h00700013);
        dbg_raddr = 5'd0;
        #1;
        chk("x0_zero", dbg_rdata, 32'h0);
        run(32'h0000007F);
        run(32'h40111193);
        for (int n = 0; n < 300; n++) run(rand_instr());
        instr_valid = 1'b1;
        instr = 32'h00900313;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("rst_mid_exec", {31'h0, instr_ready}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_wbv", {31'h0, wb_valid}, 32'd0);
        chk("rst_mid_ready", {31'h0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        exp_a = 32'h0;
        exp_b = 32'h0;
        exp_op = 4'd0;
        @(posedge clk); #1;
        chk("rst_rel_wbv", {31'h0, wb_valid}, 32'd0);
        dbg_raddr = 5'd6;
        #1;
        chk("rst_rel_x6", dbg_rdata, 32'h0);
        chk("rst_rel_ready", {31'h0, instr_ready}, 32'd1);
        run(32'h00900313);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
